logic_gate_unit: RTL

- Parametrised, registered successor to the single-bit two-input gate.
- Applies one of eight selectable bitwise gate ops to WIDTH-bit operands.
- Optionally folds successive beats of a packet into one result (accumulate mode).
- Valid/ready streaming block feeding downstream datapath; also provides reduction flags and a beat count per result.

---
 rtl/logic_gate_pkg.sv | 20 ++
 rtl/logic_gate_core.sv | 33 +++
 rtl/logic_gate_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit.
// Holds the gate op codes and the packet FSM state type used by the top
// level and the combinational gate core.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/logic_gate_core.sv
// Purely combinational bitwise gate: f = op(x, y) over WIDTH bits.
// Ports:
//   x, y : operands
//   op   : gate select (AND, OR, XOR, NAND, NOR, XNOR, NOT x, BUF x)
//   f    : result
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] f
);

    // Gate selection; NOT and BUF are unary on x.
    always_comb begin
        f = '0;
        case (op)
            OP_AND:  f = x & y;
            OP_OR:   f = x | y;
            OP_XOR:  f = x ^ y;
            OP_NAND: f = ~(x & y);
            OP_NOR:  f = ~(x | y);
            OP_XNOR: f = ~(x ^ y);
            OP_NOT:  f = ~x;
            OP_BUF:  f = x;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered, streaming bitwise gate unit with optional packet folding.
// A single beat yields f(in_a, in_b); in accumulate mode the beats of a
// packet are folded as acc = f(acc, in_a) and one result is emitted on
// the last beat, together with its reduction flags and a saturating beat
// count.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   in_valid/in_ready        : input handshake
//   in_a, in_b, in_op        : operands and op (b/op taken on first beat)
//   in_acc, in_last          : accumulate mode, last beat of packet
//   out_valid/out_ready      : output handshake
//   out_y, out_count         : result and number of beats folded into it
//   out_red_and/or/xor       : reductions of out_y
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_red_and,
    output logic             out_red_or,
    output logic             out_red_xor,
    output logic [CNTW-1:0]  out_count
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    state_t            state_r, state_nxt_s;
    logic [WIDTH-1:0]  acc_r, acc_nxt_s;
    logic [CNTW-1:0]   cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [2:0]        op_r, op_nxt_s;

    logic              accept_s;
    logic              load_s;
    logic [WIDTH-1:0]  load_y_s;
    logic [CNTW-1:0]   load_cnt_s;

    logic [WIDTH-1:0]  core_x_s, core_y_s, core_f_s;
    logic [2:0]        core_op_s;

    logic              out_valid_r;
    logic [WIDTH-1:0]  out_y_r;
    logic [CNTW-1:0]   out_count_r;
    logic              red_and_r, red_or_r, red_xor_r;

    // The output slot can take a new result if it is empty or draining now.
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Count never wraps: it sticks at the all-ones value.
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // Operand mux: first beat uses (a, b, in_op), later beats fold into acc.
    always_comb begin
        if (state_r == ACCUM) begin
            core_x_s  = acc_r;
            core_y_s  = in_a;
            core_op_s = op_r;
        end else begin
            core_x_s  = in_a;
            core_y_s  = in_b;
            core_op_s = in_op;
        end
    end

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .x  (core_x_s),
        .y  (core_y_s),
        .op (core_op_s),
        .f  (core_f_s)
    );

    // Next-state, accumulator/counter update and result load request.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        load_s      = 1'b0;
        load_y_s    = '0;
        load_cnt_s  = '0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (in_acc && !in_last) begin
                        op_nxt_s    = in_op;
                        acc_nxt_s   = core_f_s;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = ACCUM;
                    end else begin
                        load_s     = 1'b1;
                        load_y_s   = core_f_s;
                        load_cnt_s = CNT_ONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    if (in_last) begin
                        load_s      = 1'b1;
                        load_y_s    = core_f_s;
                        load_cnt_s  = cnt_inc_s;
                        acc_nxt_s   = '0;
                        cnt_nxt_s   = '0;
                        state_nxt_s = IDLE;
                    end else begin
                        acc_nxt_s = core_f_s;
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                acc_nxt_s   = '0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Packet state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            op_r    <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_r    <= op_nxt_s;
        end
    end

    // Output register: load wins over drain, so drain+load is back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_y_r     <= '0;
            out_count_r <= '0;
            red_and_r   <= 1'b0;
            red_or_r    <= 1'b0;
            red_xor_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_y_r     <= load_y_s;
            out_count_r <= load_cnt_s;
            red_and_r   <= &load_y_s;
            red_or_r    <= |load_y_s;
            red_xor_r   <= ^load_y_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_y       = out_y_r;
    assign out_count   = out_count_r;
    assign out_red_and = red_and_r;
    assign out_red_or  = red_or_r;
    assign out_red_xor = red_xor_r;

endmodule
